// File: rtl/banked_memory_pkg.sv
// Shared definitions for the banked scratch/lookup memory.
//   state_t      : sequencer state encoding (INIT, READY)
//   width_of     : bit width needed to index n items (minimum 1)
//   addr_width   : flat address width for a banks x depth arrangement
package banked_memory_pkg;

    typedef enum logic {
        ST_INIT  = 1'b0,
        ST_READY = 1'b1
    } state_t;

    function automatic int width_of(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

    function automatic int addr_width(input int banks, input int depth);
        return width_of(banks) + width_of(depth);
    endfunction

endpackage

// File: rtl/banked_memory_mem_bank.sv
// Single-port synchronous memory bank, DEPTH words of DATA_W bits.
// Ports:
//   clk    : clock, rising edge
//   en     : access enable for this cycle
//   we     : 1 = write wdata to addr, 0 = read addr
//   addr   : word offset within the bank
//   wdata  : write data
//   rdata  : registered read data, updated on an enabled read only
module mem_bank
    import banked_memory_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 4,
    localparam int OFF_W = width_of(DEPTH)
) (
    input  logic              clk,
    input  logic              en,
    input  logic              we,
    input  logic [OFF_W-1:0]  addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end else begin
                rdata <= mem[addr];
            end
        end
    end

endmodule

// File: rtl/banked_memory.sv
// Banked scratch/lookup memory with a built-in init sequencer.
// After reset every word is loaded with its own flat address (truncated to
// DATA_W), then requests are served with a one-cycle registered read.
// Ports:
//   clk          : clock, rising edge
//   rst          : synchronous active-high reset
//   ce           : chip enable, a request is accepted only when high
//   req_valid    : request strobe
//   req_ready    : block can accept a request this cycle
//   we           : 1 = write, 0 = read
//   addr         : flat address {bank, offset}
//   wdata        : write data
//   bank_en      : per-bank enable mask
//   rdata        : read data, 0 whenever rdata_valid is low
//   rdata_valid  : one-cycle pulse, read data present
//   err          : one-cycle pulse, accepted access hit a disabled bank
//   init_done    : init sequence complete
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_INIT  | sequencer writes word n = n to every address, no requests
// ST_READY | requests accepted, one per cycle, until rst
module banked_memory
    import banked_memory_pkg::*;
#(
    parameter int NUM_BANKS  = 4,
    parameter int BANK_DEPTH = 4,
    parameter int DATA_W     = 4,
    localparam int BANK_W = width_of(NUM_BANKS),
    localparam int OFF_W  = width_of(BANK_DEPTH),
    localparam int ADDR_W = BANK_W + OFF_W
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ce,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 we,
    input  logic [ADDR_W-1:0]    addr,
    input  logic [DATA_W-1:0]    wdata,
    input  logic [NUM_BANKS-1:0] bank_en,
    output logic [DATA_W-1:0]    rdata,
    output logic                 rdata_valid,
    output logic                 err,
    output logic                 init_done
);

    state_t            state;
    logic [ADDR_W-1:0] init_cnt;
    logic [BANK_W-1:0] rd_bank;

    logic [BANK_W-1:0] req_bank;
    logic [OFF_W-1:0]  req_off;
    logic              req_bank_on;
    logic              accept;
    logic              init_wr;

    // Shared bank port, driven either by the init sequencer or the request.
    logic              port_en;
    logic              port_we;
    logic [BANK_W-1:0] port_bank;
    logic [OFF_W-1:0]  port_off;
    logic [DATA_W-1:0] port_wdata;

    logic [DATA_W-1:0] bank_rdata [NUM_BANKS];

    assign req_bank    = addr[ADDR_W-1:OFF_W];
    assign req_off     = addr[OFF_W-1:0];
    assign req_bank_on = bank_en[req_bank];

    // rst wins over everything, so nothing is accepted or written in a rst cycle.
    assign accept  = req_valid & req_ready & ce & ~rst;
    assign init_wr = (state == ST_INIT) & ~rst;

    always_comb begin
        port_en    = 1'b0;
        port_we    = 1'b0;
        port_bank  = req_bank;
        port_off   = req_off;
        port_wdata = wdata;
        if (init_wr) begin
            port_en    = 1'b1;
            port_we    = 1'b1;
            port_bank  = init_cnt[ADDR_W-1:OFF_W];
            port_off   = init_cnt[OFF_W-1:0];
            // Init value wraps when there are more words than 2^DATA_W.
            port_wdata = DATA_W'(init_cnt);
        end else if (accept && req_bank_on) begin
            port_en    = 1'b1;
            port_we    = we;
        end
    end

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        mem_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (BANK_DEPTH)
        ) u_bank (
            .clk   (clk),
            .en    (port_en && (port_bank == BANK_W'(b))),
            .we    (port_we),
            .addr  (port_off),
            .wdata (port_wdata),
            .rdata (bank_rdata[b])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_INIT;
            init_cnt    <= '0;
            req_ready   <= 1'b0;
            init_done   <= 1'b0;
            rdata_valid <= 1'b0;
            rd_bank     <= '0;
            err         <= 1'b0;
        end else begin
            rdata_valid <= accept & ~we & req_bank_on;
            err         <= accept & ~req_bank_on;
            if (accept) begin
                rd_bank <= req_bank;
            end
            case (state)
                ST_INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    // Address space is exactly 2^ADDR_W words, so all-ones is the last.
                    if (&init_cnt) begin
                        state     <= ST_READY;
                        req_ready <= 1'b1;
                        init_done <= 1'b1;
                    end
                end
                ST_READY: begin
                    state <= ST_READY;
                end
                default: begin
                    state <= ST_INIT;
                end
            endcase
        end
    end

    // Bank output registers hold stale data; present 0 outside a valid pulse.
    always_comb begin
        rdata = '0;
        if (rdata_valid) begin
            rdata = bank_rdata[rd_bank];
        end
    end

endmodule

// File: tb/tb_banked_memory.sv
module tb_banked_memory;

    logic       clk = 1'b0;
    logic       rst, ce, req_valid, we;
    logic [3:0] addr, wdata, bank_en;
    logic       req_ready, rdata_valid, err, init_done;
    logic [3:0] rdata;

    logic       rst_b, ce_b, req_valid_b, we_b;
    logic [4:0] addr_b;
    logic [3:0] wdata_b, bank_en_b;
    logic       req_ready_b, rdata_valid_b, err_b, init_done_b;
    logic [3:0] rdata_b;

    int n_chk = 0;
    int n_err = 0;
    int cyc;

    always #5 clk = ~clk;

    banked_memory dut (
        .clk(clk), .rst(rst), .ce(ce), .req_valid(req_valid), .req_ready(req_ready),
        .we(we), .addr(addr), .wdata(wdata), .bank_en(bank_en), .rdata(rdata),
        .rdata_valid(rdata_valid), .err(err), .init_done(init_done)
    );

    banked_memory #(.NUM_BANKS(4), .BANK_DEPTH(8), .DATA_W(4)) dut_b (
        .clk(clk), .rst(rst_b), .ce(ce_b), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .we(we_b), .addr(addr_b), .wdata(wdata_b), .bank_en(bank_en_b), .rdata(rdata_b),
        .rdata_valid(rdata_valid_b), .err(err_b), .init_done(init_done_b)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!req_ready && n < 100) begin
            step();
            n++;
        end
    endtask

    task automatic do_write(input logic [3:0] a, input logic [3:0] d);
        req_valid = 1'b1; we = 1'b1; addr = a; wdata = d;
        step();
        req_valid = 1'b0; we = 1'b0;
    endtask

    task automatic do_read(input logic [3:0] a);
        req_valid = 1'b1; we = 1'b0; addr = a;
        step();
        req_valid = 1'b0;
    endtask

    initial begin
        rst = 1'b1; ce = 1'b1; req_valid = 1'b0; we = 1'b0;
        addr = '0; wdata = '0; bank_en = 4'hF;
        rst_b = 1'b1; ce_b = 1'b1; req_valid_b = 1'b0; we_b = 1'b0;
        addr_b = '0; wdata_b = '0; bank_en_b = 4'hF;

        // 1: reset state, init length, init contents
        step();
        step();
        chk("rst_ready", req_ready, 0);
        chk("rst_done", init_done, 0);
        chk("rst_rvalid", rdata_valid, 0);
        chk("rst_err", err, 0);
        chk("rst_rdata", rdata, 0);
        rst = 1'b0;
        wait_ready(cyc);
        chk("init_len", cyc, 16);
        chk("init_done", init_done, 1);
        for (int i = 0; i < 16; i++) begin
            do_read(4'(i));
            chk($sformatf("init_rv_%0d", i), rdata_valid, 1);
            chk($sformatf("init_rd_%0d", i), rdata, i);
        end
        step();
        chk("idle_rvalid", rdata_valid, 0);
        chk("idle_rdata_zero", rdata, 0);

        // 2: write then back-to-back read, neighbour untouched
        do_write(4'd6, 4'd9);
        chk("wr_no_rvalid", rdata_valid, 0);
        chk("wr_no_err", err, 0);
        do_read(4'd6);
        chk("raw_rv", rdata_valid, 1);
        chk("raw_rd", rdata, 9);
        do_read(4'd7);
        chk("nbr_rd", rdata, 7);

        // 3: disabled bank
        bank_en = 4'b1011;
        do_write(4'd9, 4'd3);
        chk("dis_wr_err", err, 1);
        chk("dis_wr_rv", rdata_valid, 0);
        do_read(4'd9);
        chk("dis_rd_err", err, 1);
        chk("dis_rd_rv", rdata_valid, 0);
        chk("dis_rd_data", rdata, 0);
        do_read(4'd13);
        chk("en_rd_err", err, 0);
        chk("en_rd_data", rdata, 13);
        bank_en = 4'hF;
        do_read(4'd9);
        chk("dropped_wr", rdata, 9);

        // 4: ce=0 requests ignored
        ce = 1'b0; req_valid = 1'b1; we = 1'b1; addr = 4'd2; wdata = 4'd15;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("ce0_rv", rdata_valid, 0);
            chk("ce0_err", err, 0);
        end
        req_valid = 1'b0; we = 1'b0; ce = 1'b1;
        do_read(4'd2);
        chk("ce0_rd", rdata, 2);

        // 5: reset mid-INIT restarts, request in rst cycle discarded
        rst = 1'b1;
        step();
        rst = 1'b0;
        for (int i = 0; i < 8; i++) step();
        chk("mid_init_ready", req_ready, 0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        wait_ready(cyc);
        chk("reinit_len", cyc, 16);
        do_read(4'd6);
        chk("reinit_rd6", rdata, 6);
        req_valid = 1'b1; we = 1'b0; addr = 4'd3; rst = 1'b1;
        step();
        chk("rst_req_rv", rdata_valid, 0);
        req_valid = 1'b0; rst = 1'b0;
        step();
        chk("rst_req_rv2", rdata_valid, 0);
        wait_ready(cyc);
        chk("reinit2_len", cyc, 15);

        // 6: 4x8 instance, init wrap and sustained reads
        rst_b = 1'b0;
        cyc = 0;
        while (!req_ready_b && cyc < 100) begin
            step();
            cyc++;
        end
        chk("b_init_len", cyc, 32);
        req_valid_b = 1'b1; addr_b = 5'd16;
        step();
        chk("b_rd16", rdata_b, 0);
        addr_b = 5'd31;
        step();
        chk("b_rd31", rdata_b, 15);
        req_valid_b = 1'b0;
        step();
        req_valid_b = 1'b1;
        for (int i = 0; i < 32; i++) begin
            addr_b = 5'(i);
            step();
            chk($sformatf("b_rv_%0d", i), rdata_valid_b, 1);
            chk($sformatf("b_rd_%0d", i), rdata_b, i % 16);
        end
        req_valid_b = 1'b0;

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
